parallel_io_bank: RTL and testbench



---
 rtl/parallel_io_bank.sv | 156 +++++++++++++++
 tb/tb_parallel_io_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/parallel_io_bank.sv
// parallel_io_bank
//   Memory-mapped parallel I/O bank for the 8-bit single-cycle core.
//   N_OUT writable output ports, N_IN synchronised input ports, sticky
//   change flags (write-1-to-clear), an interrupt mask and a registered irq.
//
//   Address map, as an offset from BASE_ADDR:
//     0 .. N_OUT-1              OUT[i]  read/write
//     N_OUT .. N_OUT+N_IN-1     IN[i]   read-only
//     N_OUT+N_IN                FLAGS   W1C, bits [N_IN-1:0]
//     N_OUT+N_IN+1              MASK    R/W, bits [N_IN-1:0]
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   we       write strobe
//   addr     byte address
//   wdata    write data
//   rdata    combinational read data for addr (0 when not hit)
//   hit      combinational, addr lies inside the bank
//   in_pins  asynchronous inputs, port i at [i*DATA_W +: DATA_W]
//   out_pins registered outputs, port i at [i*DATA_W +: DATA_W]
//   irq      registered OR of (FLAGS & MASK)
module parallel_io_bank #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                N_OUT     = 4,
  parameter int                N_IN      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    hit,
  input  logic [N_IN*DATA_W-1:0]  in_pins,
  output logic [N_OUT*DATA_W-1:0] out_pins,
  output logic                    irq
);

  localparam int                N_REGS    = N_OUT + N_IN + 2;
  localparam logic [ADDR_W-1:0] OFF_FLAGS = ADDR_W'(N_OUT + N_IN);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(N_OUT + N_IN + 1);
  // One bit wider so a bank ending exactly at 2^ADDR_W is still representable.
  localparam logic [ADDR_W:0]   END_ADDR  = {1'b0, BASE_ADDR} + (ADDR_W+1)'(N_REGS);

  logic [ADDR_W-1:0] offset;
  logic              wr_en;

  logic [DATA_W-1:0] out_val [N_OUT];
  logic [DATA_W-1:0] in_val  [N_IN];
  logic [N_IN-1:0]   changed;

  logic [1:0]        arm_q, arm_d;
  logic              armed;
  logic [N_IN-1:0]   flags_q, flags_d, flags_clr;
  logic [N_IN-1:0]   mask_q, mask_d;
  logic              irq_q, irq_d;

  // ---------------------------------------------------------------- decode
  assign offset = addr - BASE_ADDR;
  assign hit    = (addr >= BASE_ADDR) && ({1'b0, addr} < END_ADDR);
  assign wr_en  = we && hit;

  // ---------------------------------------------------------- output ports
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [DATA_W-1:0] out_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else if (wr_en && (offset == ADDR_W'(gi))) begin
          out_q <= wdata;
        end
      end

      assign out_val[gi]                    = out_q;
      assign out_pins[gi*DATA_W +: DATA_W] = out_q;
    end
  endgenerate

  // ----------------------------------------------------------- input ports
  // s1/s2 form the synchroniser; s3 holds the previous synchronised value so
  // a difference between s2 and s3 marks a change seen this cycle.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic [DATA_W-1:0] s1_q, s2_q, s3_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q <= '0;
          s2_q <= '0;
          s3_q <= '0;
        end else begin
          s1_q <= in_pins[gi*DATA_W +: DATA_W];
          s2_q <= s1_q;
          s3_q <= s2_q;
        end
      end

      assign in_val[gi]  = s2_q;
      assign changed[gi] = armed && (s2_q != s3_q);
    end
  endgenerate

  // --------------------------------------------------- flags, mask and irq
  // Detection stays off until the pipeline has refilled after reset, so a
  // pin held non-zero through reset does not look like a change.
  assign armed = (arm_q == 2'd3);

  always_comb begin
    arm_d     = armed ? arm_q : arm_q + 2'd1;
    flags_clr = '0;
    mask_d    = mask_q;
    if (wr_en && (offset == OFF_FLAGS)) flags_clr = wdata[N_IN-1:0];
    if (wr_en && (offset == OFF_MASK))  mask_d    = wdata[N_IN-1:0];
    // OR-ing the set term last makes a new change win over a same-cycle clear.
    flags_d = (flags_q & ~flags_clr) | changed;
    irq_d   = |(flags_d & mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= 2'd0;
      flags_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

  // ------------------------------------------------------------- read mux
  always_comb begin
    rdata = '0;
    if (hit) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (offset == ADDR_W'(i)) rdata = out_val[i];
      end
      for (int i = 0; i < N_IN; i++) begin
        if (offset == ADDR_W'(N_OUT + i)) rdata = in_val[i];
      end
      if (offset == OFF_FLAGS) rdata = DATA_W'(flags_q);
      if (offset == OFF_MASK)  rdata = DATA_W'(mask_q);
    end
  end

endmodule

// File: tb/tb_parallel_io_bank.sv
// Testbench for parallel_io_bank: table-driven register accesses with an
// out_pins scoreboard, plus hand-written multi-cycle input/flag sequences.
module tb_parallel_io_bank;

  logic        clk;
  logic        rst;
  logic        we;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hit;
  logic [31:0] in_pins;
  logic [31:0] out_pins;
  logic        irq;

  parallel_io_bank #(
    .DATA_W(8), .ADDR_W(8), .N_OUT(4), .N_IN(4), .BASE_ADDR(8'hF0)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hit(hit), .in_pins(in_pins), .out_pins(out_pins),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0] port;
    logic [7:0] value;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_hit;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one access; a write to an output port outside reset queues the
  // value expected on out_pins after the next edge.
  task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    if (w && !rst && a >= 8'hF0 && a <= 8'hF3) begin
      sb_t e;
      e.port  = a[1:0];
      e.value = d;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check($sformatf("sb_out%0d", e.port), 32'(out_pins[e.port*8 +: 8]), 32'(e.value));
    end
  endtask

  initial begin
    // register-access vectors, applied after reset with in_pins = 0
    vecs[0]  = '{1'b0, 8'hF0, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 8'hF1, 8'hA5, 1'b1, 8'h00}; // read shows old value
    vecs[2]  = '{1'b0, 8'hF1, 8'h00, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'hF0, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 8'hF3, 8'h3C, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 8'hF3, 8'h00, 1'b1, 8'h3C};
    vecs[6]  = '{1'b1, 8'hF5, 8'h77, 1'b1, 8'h00}; // input port, write ignored
    vecs[7]  = '{1'b0, 8'hF5, 8'h00, 1'b1, 8'h00};
    vecs[8]  = '{1'b1, 8'hFA, 8'h77, 1'b0, 8'h00}; // past end of bank
    vecs[9]  = '{1'b1, 8'hE0, 8'h77, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'hEF, 8'h00, 1'b0, 8'h00}; // just below base
    vecs[11] = '{1'b1, 8'hF9, 8'hFF, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 8'hF9, 8'h00, 1'b1, 8'h0F}; // upper mask bits dropped
    vecs[13] = '{1'b1, 8'hF9, 8'h04, 1'b1, 8'h0F};
    vecs[14] = '{1'b0, 8'hF9, 8'h00, 1'b1, 8'h04};
    vecs[15] = '{1'b0, 8'hF8, 8'h00, 1'b1, 8'h00};
    vecs[16] = '{1'b1, 8'hF0, 8'h12, 1'b1, 8'h00};
    vecs[17] = '{1'b0, 8'hF0, 8'h00, 1'b1, 8'h12};

    // ---------------- reset, with a write attempted during reset
    rst     = 1'b1;
    in_pins = '0;
    drive(1'b1, 8'hF0, 8'h55);
    tick();
    tick();
    check("rst_out_pins", out_pins, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    drive(1'b0, 8'hF0, 8'h00);
    check("rst_rd_out0", 32'(rdata), 32'h0);
    check("rst_hit_comb", 32'(hit), 32'h1);
    rst = 1'b0;

    // ---------------- table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      tick();
    end
    check("tbl_out_pins", out_pins, 32'h3C00_A512);
    check("tbl_irq", 32'(irq), 32'h0);

    // ---------------- input change on port 2, MASK = 04
    in_pins[23:16] = 8'h3C;
    drive(1'b0, 8'hF6, 8'h00);
    check("in_rd_pre", 32'(rdata), 32'h00);
    tick();                                   // edge N
    check("in_rd_n", 32'(rdata), 32'h00);
    tick();                                   // edge N+1
    check("in_rd_n1", 32'(rdata), 32'h3C);
    drive(1'b0, 8'hF8, 8'h00);
    check("flag_n1", 32'(rdata), 32'h00);
    check("irq_n1", 32'(irq), 32'h0);
    tick();                                   // edge N+2
    check("flag_n2", 32'(rdata), 32'h04);
    check("irq_n2", 32'(irq), 32'h1);

    // ---------------- W1C with port 2 stable
    drive(1'b1, 8'hF8, 8'h04);
    check("w1c_rd_old", 32'(rdata), 32'h04);
    tick();
    drive(1'b0, 8'hF8, 8'h00);
    check("w1c_flag", 32'(rdata), 32'h00);
    check("w1c_irq", 32'(irq), 32'h0);

    // ---------------- clear in the same cycle as a new change: set wins
    in_pins[23:16] = 8'h5A;
    drive(1'b0, 8'hF6, 8'h00);
    tick();
    tick();                                   // s2 != s3 this cycle
    check("sw_rd_in", 32'(rdata), 32'h5A);
    drive(1'b1, 8'hF8, 8'h04);
    tick();
    drive(1'b0, 8'hF8, 8'h00);
    check("sw_flag", 32'(rdata), 32'h04);
    check("sw_irq", 32'(irq), 32'h1);

    // ---------------- pins held high through reset: no spurious flags
    in_pins = 32'hFFFF_FFFF;
    rst     = 1'b1;
    drive(1'b0, 8'hF8, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b1, 8'hF9, 8'h0F);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 8'hF8, 8'h00);
      check($sformatf("hold_flag_c%0d", c), 32'(rdata), 32'h00);
      check($sformatf("hold_irq_c%0d", c), 32'(irq), 32'h0);
      tick();
    end
    drive(1'b0, 8'hF9, 8'h00);
    check("hold_mask", 32'(rdata), 32'h0F);
    drive(1'b0, 8'hF4, 8'h00);
    check("hold_in0", 32'(rdata), 32'hFF);

    // ---------------- reset mid-operation
    drive(1'b1, 8'hF0, 8'h12);
    tick();
    in_pins = 32'h0;
    drive(1'b0, 8'hF8, 8'h00);
    tick();
    tick();
    tick();
    check("mid_flags", 32'(rdata), 32'h0F);
    check("mid_irq", 32'(irq), 32'h1);
    check("mid_out0", 32'(out_pins[7:0]), 32'h12);
    rst = 1'b1;
    tick();
    check("mid_rst_out_pins", out_pins, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    drive(1'b0, 8'hF8, 8'h00);
    check("mid_rst_flags", 32'(rdata), 32'h00);
    drive(1'b0, 8'hF9, 8'h00);
    check("mid_rst_mask", 32'(rdata), 32'h00);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
